nts_tx_arbiter: RTL and testbench
=================================

// Module: nts_tx_arbiter
// PURPOSE
// - Round-robin arbiter between ENGINES nts_engine TX buffer interfaces and the single engine-side port of nts_extractor.
// - Grants one engine per packet; holds the grant until the extractor signals packet read, then rotates priority.
// - Sits between the engine array and the extractor, removing the one-engine-only restriction on the TX path.
// PARAMETERS
// - ENGINES         4     number of engine TX interfaces (1..16)
// - GRANT_WIDTH     2     width of grant index; must be >= clog2(ENGINES), and >= 1
// - MAC_DATA_WIDTH  64    TX FIFO word width
// - WATCHDOG_CYCLES 4096  max cycles a grant may be held (only with NTS_TX_ARBITER_WATCHDOG_EN)
// PORTS
// - i_clk                         in  1                     clock
// - i_areset                      in  1                     reset, asynchronous, active-high
// - i_engine_packet_available     in  ENGINES               per-engine TX packet ready
// - o_engine_packet_read          out ENGINES               per-engine packet-read pulse
// - i_engine_fifo_empty           in  ENGINES               per-engine TX FIFO empty
// - o_engine_fifo_rd_en           out ENGINES               per-engine FIFO read enable
// - i_engine_fifo_rd_data         in  MAC_DATA_WIDTH*ENGINES packed FIFO data, engine n at [n*W +: W]
// - i_engine_bytes_last_word      in  4*ENGINES             packed valid-byte count of last word
// - o_extractor_packet_available  out 1                     to extractor
// - i_extractor_packet_read       in  1                     from extractor, 1-cycle pulse
// - o_extractor_fifo_empty        out 1                     to extractor
// - i_extractor_fifo_rd_en        in  1                     from extractor
// - o_extractor_fifo_rd_data      out MAC_DATA_WIDTH        to extractor
// - o_extractor_bytes_last_word   out 4                     to extractor
// - o_grant_index                 out GRANT_WIDTH           currently/last granted engine
// - o_busy                        out 1                     state != IDLE
// - o_watchdog_expired            out 1                     1-cycle pulse on watchdog release (0 without macro)
// BEHAVIOUR
// - Reset: state IDLE, o_grant_index 0, last-served pointer ENGINES-1 (engine 0 highest priority first),
//   all o_engine_* 0, o_extractor_packet_available 0, o_extractor_fifo_empty 1, bytes_last_word 0, o_busy 0, o_watchdog_expired 0.
// - States: IDLE -> GRANTED -> RELEASE -> IDLE.
// - IDLE: search from (last+1) mod ENGINES upward, wrapping; first engine with packet_available wins.
//   Grant index and last pointer registered; GRANTED entered next cycle. No requester: stay IDLE.
// - GRANTED: combinational pass-through for granted engine g only:
//   packet_available, fifo_empty, bytes_last_word -> extractor; i_extractor_fifo_rd_en -> o_engine_fifo_rd_en[g];
//   i_extractor_packet_read -> o_engine_packet_read[g] in the same cycle; then -> RELEASE.
// - RELEASE: exactly one cycle; extractor sees available 0, empty 1; lets engine deassert its registered available; -> IDLE.
// - o_extractor_fifo_rd_data always muxed from engine o_grant_index (zero added latency; engine read latency preserved).
// - Outside GRANTED: i_extractor_fifo_rd_en and i_extractor_packet_read ignored, never forwarded; o_engine_* all 0.
// - Granted engine dropping available without packet_read: grant held, extractor sees available 0.
// - Requests changing during GRANTED/RELEASE: no effect until IDLE evaluation.
// - o_engine_packet_read and o_engine_fifo_rd_en are one-hot or zero at all times.
// - Reset mid-packet: immediate return to reset values; partially read engine packet left to engine.
// CONFIGURATION
// - NTS_TX_ARBITER_WATCHDOG_EN defined: 16-bit cycle counter cleared on entering GRANTED, increments each GRANTED cycle;
//   at count == WATCHDOG_CYCLES-1 without packet_read: pulse o_engine_packet_read[g] (engine discards packet),
//   pulse o_watchdog_expired, -> RELEASE. packet_read in same cycle wins: normal release, no expired pulse.
// - Not defined: no counter, grant held indefinitely, o_watchdog_expired tied 0.
// TESTING
// - Reset, no requests, 100 cycles -> o_busy 0, extractor available 0, empty 1, all o_engine_* 0.
// - Engine 2 only available, 3 words, extractor reads 3 then packet_read -> grant 2, 3 rd_en pulses on [2] only, read pulse on [2], RELEASE 1 cycle.
// - Engines 0,1,3 all requesting continuously -> grants in order 0,1,3,0,1,3; each grant shows IDLE/GRANTED/RELEASE sequence.
// - After serving engine 3, request from 0 and 3 simultaneously -> engine 0 granted (wrap-around).
// - rd_en/packet_read pulsed during IDLE and RELEASE -> no o_engine_* activity.
// - Watchdog (macro on, WATCHDOG_CYCLES=16): engine 1 granted, no read -> after 16 GRANTED cycles read pulse [1], o_watchdog_expired 1 cycle.

Source files
------------

// File: rtl/nts_tx_arbiter_if.sv
// ============================================================================
// Module     : nts_tx_arbiter_if
// Description: Engine-array and extractor handshake/data bundle for the TX arbiter.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

interface nts_tx_arbiter_if #(
    parameter int ENGINES        = 4,
    parameter int MAC_DATA_WIDTH = 64
);
    // Engine-array side (direction as seen by the arbiter)
    logic [ENGINES-1:0]                i_engine_packet_available;
    logic [ENGINES-1:0]                o_engine_packet_read;
    logic [ENGINES-1:0]                i_engine_fifo_empty;
    logic [ENGINES-1:0]                o_engine_fifo_rd_en;
    logic [MAC_DATA_WIDTH*ENGINES-1:0] i_engine_fifo_rd_data;
    logic [4*ENGINES-1:0]              i_engine_bytes_last_word;

    // Extractor side
    logic                      o_extractor_packet_available;
    logic                      i_extractor_packet_read;
    logic                      o_extractor_fifo_empty;
    logic                      i_extractor_fifo_rd_en;
    logic [MAC_DATA_WIDTH-1:0] o_extractor_fifo_rd_data;
    logic [3:0]                o_extractor_bytes_last_word;

    // Arbiter view
    modport master (
        input  i_engine_packet_available,
        output o_engine_packet_read,
        input  i_engine_fifo_empty,
        output o_engine_fifo_rd_en,
        input  i_engine_fifo_rd_data,
        input  i_engine_bytes_last_word,
        output o_extractor_packet_available,
        input  i_extractor_packet_read,
        output o_extractor_fifo_empty,
        input  i_extractor_fifo_rd_en,
        output o_extractor_fifo_rd_data,
        output o_extractor_bytes_last_word
    );

    // Engines plus extractor view
    modport slave (
        output i_engine_packet_available,
        input  o_engine_packet_read,
        output i_engine_fifo_empty,
        input  o_engine_fifo_rd_en,
        output i_engine_fifo_rd_data,
        output i_engine_bytes_last_word,
        input  o_extractor_packet_available,
        output i_extractor_packet_read,
        input  o_extractor_fifo_empty,
        output i_extractor_fifo_rd_en,
        input  o_extractor_fifo_rd_data,
        input  o_extractor_bytes_last_word
    );
endinterface

`default_nettype wire

// File: rtl/nts_tx_arbiter.sv
// ============================================================================
// Module     : nts_tx_arbiter
// Description: Per-packet round-robin arbiter from ENGINES TX buffers to one extractor.
//              Optional grant watchdog: define NTS_TX_ARBITER_WATCHDOG_EN.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module nts_tx_arbiter #(
    parameter int ENGINES         = 4,
    parameter int GRANT_WIDTH     = 2,
    parameter int MAC_DATA_WIDTH  = 64,
    parameter int WATCHDOG_CYCLES = 4096
) (
    input  wire logic                   i_clk,
    input  wire logic                   i_areset,
    nts_tx_arbiter_if.master            bus,
    output logic [GRANT_WIDTH-1:0]      o_grant_index,
    output logic                        o_busy,
    output logic                        o_watchdog_expired
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [GRANT_WIDTH-1:0]   r_grant;
    logic [GRANT_WIDTH-1:0]   r_last;
    logic [GRANT_WIDTH-1:0]   w_sel;
    logic                     w_found;
    logic                     w_wd_fire;
    logic [ENGINES-1:0]       w_eng_rd_en;
    logic [ENGINES-1:0]       w_eng_pkt_read;
    logic                     w_xtr_avail;
    logic                     w_xtr_empty;
    logic [3:0]               w_xtr_blw;

    // Scan from the farthest candidate back to the nearest so the nearest
    // requester after the last-served engine is the one left in w_sel.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_last;
        for (int k = ENGINES; k >= 1; k--) begin
            if (bus.i_engine_packet_available[(int'(r_last) + k) % ENGINES]) begin
                w_found = 1'b1;
                w_sel   = GRANT_WIDTH'((int'(r_last) + k) % ENGINES);
            end
        end
    end

`ifdef NTS_TX_ARBITER_WATCHDOG_EN
    logic [15:0] r_wd_cnt;
    logic        w_wd_hit;

    // Held at zero while idle so the first GRANTED cycle sees count 0.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            r_wd_cnt <= 16'd0;
        end else if (r_state == ST_GRANTED) begin
            r_wd_cnt <= r_wd_cnt + 16'd1;
        end else begin
            r_wd_cnt <= 16'd0;
        end
    end

    assign w_wd_hit = (r_wd_cnt == 16'(WATCHDOG_CYCLES - 1));
`endif

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            r_grant <= '0;
            r_last  <= GRANT_WIDTH'(ENGINES - 1);
        end else if (r_state == ST_IDLE && w_found) begin
            r_grant <= w_sel;
            r_last  <= w_sel;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_eng_rd_en    = '0;
        w_eng_pkt_read = '0;
        w_xtr_avail    = 1'b0;
        w_xtr_empty    = 1'b1;
        w_xtr_blw      = 4'd0;
        w_wd_fire      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_GRANTED;
                end
            end
            ST_GRANTED: begin
                w_xtr_avail             = bus.i_engine_packet_available[r_grant];
                w_xtr_empty             = bus.i_engine_fifo_empty[r_grant];
                w_xtr_blw               = bus.i_engine_bytes_last_word[int'(r_grant)*4 +: 4];
                w_eng_rd_en[r_grant]    = bus.i_extractor_fifo_rd_en;
                w_eng_pkt_read[r_grant] = bus.i_extractor_packet_read;
`ifdef NTS_TX_ARBITER_WATCHDOG_EN
                if (bus.i_extractor_packet_read) begin
                    w_state_nxt = ST_RELEASE;
                end else if (w_wd_hit) begin
                    // Forced read pulse makes the engine drop the stuck packet.
                    w_eng_pkt_read[r_grant] = 1'b1;
                    w_wd_fire               = 1'b1;
                    w_state_nxt             = ST_RELEASE;
                end
`else
                if (bus.i_extractor_packet_read) begin
                    w_state_nxt = ST_RELEASE;
                end
`endif
            end
            ST_RELEASE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.o_engine_fifo_rd_en          = w_eng_rd_en;
    assign bus.o_engine_packet_read         = w_eng_pkt_read;
    assign bus.o_extractor_packet_available = w_xtr_avail;
    assign bus.o_extractor_fifo_empty       = w_xtr_empty;
    assign bus.o_extractor_bytes_last_word  = w_xtr_blw;
    // Data follows the grant index in every state so FIFO read latency is untouched.
    assign bus.o_extractor_fifo_rd_data     =
        bus.i_engine_fifo_rd_data[int'(r_grant)*MAC_DATA_WIDTH +: MAC_DATA_WIDTH];
    assign o_grant_index                    = r_grant;
    assign o_busy                           = (r_state != ST_IDLE);
    assign o_watchdog_expired               = w_wd_fire;

endmodule

`default_nettype wire

// File: tb/tb_nts_tx_arbiter.sv
// ============================================================================
// Module     : tb_nts_tx_arbiter
// Description: Directed, table-driven bench for nts_tx_arbiter (4 engines, 64-bit data).
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nts_tx_arbiter;

    localparam int ENGINES = 4;
    localparam int GW      = 2;
    localparam int W       = 64;

    logic          clk;
    logic          areset;
    logic [GW-1:0] grant_index;
    logic          busy;
    logic          wd_expired;

    int n_vec;
    int n_bad;

    nts_tx_arbiter_if #(.ENGINES(ENGINES), .MAC_DATA_WIDTH(W)) u_if ();

    nts_tx_arbiter #(
        .ENGINES        (ENGINES),
        .GRANT_WIDTH    (GW),
        .MAC_DATA_WIDTH (W),
        .WATCHDOG_CYCLES(16)
    ) u_dut (
        .i_clk              (clk),
        .i_areset           (areset),
        .bus                (u_if),
        .o_grant_index      (grant_index),
        .o_busy             (busy),
        .o_watchdog_expired (wd_expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] av;
        logic [3:0] em;
        logic       rd;
        logic       pr;
        logic       busy;
        logic       xav;
        logic       xe;
        logic [3:0] erd;
        logic [3:0] epr;
        logic [1:0] gnt;
        logic [3:0] blw;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [3:0] av, input logic [3:0] em, input logic rd,
                                input logic pr, input logic b, input logic xav, input logic xe,
                                input logic [3:0] erd, input logic [3:0] epr,
                                input logic [1:0] gnt, input logic [3:0] blw);
        vec_t v;
        v = '{av, em, rd, pr, b, xav, xe, erd, epr, gnt, blw};
        tbl.push_back(v);
    endfunction

    function automatic logic [W-1:0] data_of(input logic [1:0] g);
        return {8{8'hA0 + {6'd0, g}}};
    endfunction

    task automatic drive(input logic [3:0] av, input logic [3:0] em, input logic rd, input logic pr);
        u_if.i_engine_packet_available = av;
        u_if.i_engine_fifo_empty       = em;
        u_if.i_extractor_fifo_rd_en    = rd;
        u_if.i_extractor_packet_read   = pr;
    endtask

    task automatic check(input string name, input logic e_busy, input logic e_xav, input logic e_xe,
                         input logic [3:0] e_erd, input logic [3:0] e_epr, input logic [1:0] e_gnt,
                         input logic [3:0] e_blw, input logic e_wd);
        logic [W-1:0] e_data;
        e_data = data_of(e_gnt);
        n_vec++;
        if (busy !== e_busy || u_if.o_extractor_packet_available !== e_xav ||
            u_if.o_extractor_fifo_empty !== e_xe || u_if.o_engine_fifo_rd_en !== e_erd ||
            u_if.o_engine_packet_read !== e_epr || grant_index !== e_gnt ||
            u_if.o_extractor_bytes_last_word !== e_blw ||
            u_if.o_extractor_fifo_rd_data !== e_data || wd_expired !== e_wd) begin
            n_bad++;
            $display("FAIL %s: got busy=%b av=%b em=%b rd=%b pr=%b gnt=%0d blw=%0d data=%h wd=%b ; want busy=%b av=%b em=%b rd=%b pr=%b gnt=%0d blw=%0d data=%h wd=%b",
                     name, busy, u_if.o_extractor_packet_available, u_if.o_extractor_fifo_empty,
                     u_if.o_engine_fifo_rd_en, u_if.o_engine_packet_read, grant_index,
                     u_if.o_extractor_bytes_last_word, u_if.o_extractor_fifo_rd_data, wd_expired,
                     e_busy, e_xav, e_xe, e_erd, e_epr, e_gnt, e_blw, e_data, e_wd);
        end
    endtask

    task automatic do_reset();
        areset = 1'b1;
        drive(4'b0000, 4'b1111, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        areset = 1'b0;
    endtask

    initial begin
        int seq[6];
        int prev;
        n_vec = 0;
        n_bad = 0;
        areset = 1'b0;
        for (int n = 0; n < ENGINES; n++) begin
            u_if.i_engine_fifo_rd_data[n*W +: W]    = data_of(2'(n));
            u_if.i_engine_bytes_last_word[n*4 +: 4] = 4'(n + 4);
        end

        // Round robin over engines 0,1,3 with all three requesting continuously
        seq  = '{0, 1, 3, 0, 1, 3};
        prev = 0;
        foreach (seq[i]) begin
            add(4'b1011, 4'b1111, 0, 0, 0, 0, 1, 4'b0000, 4'b0000, 2'(prev), 4'd0);
            add(4'b1011, 4'b1111, 0, 1, 1, 1, 1, 4'b0000, 4'(1 << seq[i]), 2'(seq[i]), 4'(seq[i] + 4));
            add(4'b1011, 4'b1111, 0, 0, 1, 0, 1, 4'b0000, 4'b0000, 2'(seq[i]), 4'd0);
            prev = seq[i];
        end
        // Wrap-around: last served 3, requests 0 and 3 -> 0
        add(4'b1001, 4'b1111, 0, 0, 0, 0, 1, 4'b0000, 4'b0000, 2'd3, 4'd0);
        add(4'b1001, 4'b1111, 0, 1, 1, 1, 1, 4'b0000, 4'b0001, 2'd0, 4'd4);
        add(4'b0000, 4'b1111, 0, 0, 1, 0, 1, 4'b0000, 4'b0000, 2'd0, 4'd0);
        // Engine 2 alone, 3 words then packet_read
        add(4'b0100, 4'b1011, 0, 0, 0, 0, 1, 4'b0000, 4'b0000, 2'd0, 4'd0);
        add(4'b0100, 4'b1011, 0, 0, 1, 1, 0, 4'b0000, 4'b0000, 2'd2, 4'd6);
        add(4'b0100, 4'b1011, 1, 0, 1, 1, 0, 4'b0100, 4'b0000, 2'd2, 4'd6);
        add(4'b0100, 4'b1011, 1, 0, 1, 1, 0, 4'b0100, 4'b0000, 2'd2, 4'd6);
        add(4'b0100, 4'b1011, 1, 0, 1, 1, 0, 4'b0100, 4'b0000, 2'd2, 4'd6);
        add(4'b0100, 4'b1111, 0, 1, 1, 1, 1, 4'b0000, 4'b0100, 2'd2, 4'd6);
        // Strobes in RELEASE and IDLE must not reach any engine
        add(4'b0100, 4'b1111, 1, 1, 1, 0, 1, 4'b0000, 4'b0000, 2'd2, 4'd0);
        add(4'b0000, 4'b1111, 1, 1, 0, 0, 1, 4'b0000, 4'b0000, 2'd2, 4'd0);
        add(4'b0010, 4'b1101, 1, 1, 0, 0, 1, 4'b0000, 4'b0000, 2'd2, 4'd0);
        // Granted engine 1 drops available, engine 3 requests meanwhile
        add(4'b1000, 4'b1101, 1, 0, 1, 0, 0, 4'b0010, 4'b0000, 2'd1, 4'd5);
        add(4'b1000, 4'b1101, 0, 1, 1, 0, 0, 4'b0000, 4'b0010, 2'd1, 4'd5);
        add(4'b1000, 4'b1111, 0, 0, 1, 0, 1, 4'b0000, 4'b0000, 2'd1, 4'd0);
        add(4'b1000, 4'b1111, 0, 0, 0, 0, 1, 4'b0000, 4'b0000, 2'd1, 4'd0);
        add(4'b1000, 4'b1111, 0, 1, 1, 1, 1, 4'b0000, 4'b1000, 2'd3, 4'd7);
        add(4'b0000, 4'b1111, 0, 0, 1, 0, 1, 4'b0000, 4'b0000, 2'd3, 4'd0);
        add(4'b0000, 4'b1111, 0, 0, 0, 0, 1, 4'b0000, 4'b0000, 2'd3, 4'd0);

        do_reset();
        #1 check("reset", 0, 0, 1, 4'b0, 4'b0, 2'd0, 4'd0, 0);

        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            drive(4'b0000, 4'b1111, 1'b0, 1'b0);
            #1 check("idle100", 0, 0, 1, 4'b0, 4'b0, 2'd0, 4'd0, 0);
        end

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].av, tbl[i].em, tbl[i].rd, tbl[i].pr);
            #1 check($sformatf("vec%0d", i), tbl[i].busy, tbl[i].xav, tbl[i].xe, tbl[i].erd,
                     tbl[i].epr, tbl[i].gnt, tbl[i].blw, 1'b0);
        end

        // Asynchronous reset in the middle of a granted packet
        do_reset();
        @(negedge clk);
        drive(4'b0010, 4'b1101, 1'b0, 1'b0);
        #1 check("mid_idle", 0, 0, 1, 4'b0, 4'b0, 2'd0, 4'd0, 0);
        @(negedge clk);
        drive(4'b0010, 4'b1101, 1'b1, 1'b0);
        #1 check("mid_grant", 1, 1, 0, 4'b0010, 4'b0, 2'd1, 4'd5, 0);
        areset = 1'b1;
        #1 check("mid_reset", 0, 0, 1, 4'b0, 4'b0, 2'd0, 4'd0, 0);
        do_reset();

        // Grant held with no packet_read: watchdog release or indefinite hold
        @(negedge clk);
        drive(4'b0010, 4'b1101, 1'b0, 1'b0);
        #1 check("wd_idle", 0, 0, 1, 4'b0, 4'b0, 2'd0, 4'd0, 0);
`ifdef NTS_TX_ARBITER_WATCHDOG_EN
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            #1 check($sformatf("wd_hold%0d", c), 1, 1, 0, 4'b0, 4'b0, 2'd1, 4'd5, 0);
        end
        @(negedge clk);
        #1 check("wd_fire", 1, 1, 0, 4'b0, 4'b0010, 2'd1, 4'd5, 1);
        @(negedge clk);
        drive(4'b0000, 4'b1111, 1'b0, 1'b0);
        #1 check("wd_release", 1, 0, 1, 4'b0, 4'b0, 2'd1, 4'd0, 0);
`else
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            #1 check($sformatf("hold%0d", c), 1, 1, 0, 4'b0, 4'b0, 2'd1, 4'd5, 0);
        end
        @(negedge clk);
        drive(4'b0010, 4'b1101, 1'b0, 1'b1);
        #1 check("hold_read", 1, 1, 0, 4'b0, 4'b0010, 2'd1, 4'd5, 0);
        @(negedge clk);
        drive(4'b0000, 4'b1111, 1'b0, 1'b0);
        #1 check("hold_release", 1, 0, 1, 4'b0, 4'b0, 2'd1, 4'd0, 0);
`endif
        @(negedge clk);
        #1 check("final_idle", 0, 0, 1, 4'b0, 4'b0, 2'd1, 4'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
